alu_ctrl_seq: RTL

Multicycle control sequencer that drives the 22-bit `ctrl_in` word of the stage-3 ALU datapath and consumes its `alu_zero` / `ovfl` flags. It is the producing end of the ALU control interface. It steps each instruction through FETCH, DECODE, EXEC, MEM, WB and BRANCH states and accepts operation classes from the decoder via a valid/ready handshake. It sits between the instruction decoder and the ALU stage and also emits the PC, IR, register-file, memory and Z write strobes.

---
 rtl/alu_ctrl_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB/BRANCH sequencer producing the 22-bit ALU control word.
// Optional build macro ALU_OVF_TRAP_EN: overflow on ADD/SUB/ADDI traps instead of writing back.
module alu_ctrl_seq #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [OPW-1:0] op_class,
    input  logic [1:0]     op_fn,
    input  logic           alu_zero,
    input  logic           ovfl,
    output logic [21:0]    ctrl_out,
    output logic           done,
    output logic           trap,
    input  logic           trap_clr
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_TRAP
    } state_t;

    localparam logic [OPW-1:0] C_ADD   = OPW'(0);
    localparam logic [OPW-1:0] C_SUB   = OPW'(1);
    localparam logic [OPW-1:0] C_LOGIC = OPW'(2);
    localparam logic [OPW-1:0] C_SHIFT = OPW'(3);
    localparam logic [OPW-1:0] C_ADDI  = OPW'(4);
    localparam logic [OPW-1:0] C_LOAD  = OPW'(5);
    localparam logic [OPW-1:0] C_STORE = OPW'(6);
    localparam logic [OPW-1:0] C_BEQ   = OPW'(7);
    localparam logic [OPW-1:0] C_BNE   = OPW'(8);

    localparam int B_ADDSUB = 2;
    localparam int B_PCW    = 8;
    localparam int B_IRW    = 9;
    localparam int B_REGW   = 10;
    localparam int B_MEMRD  = 11;
    localparam int B_MEMWR  = 12;
    localparam int B_ZW     = 13;

    state_t          r_state;
    state_t          w_next;
    logic [OPW-1:0]  r_op_class;
    logic [1:0]      r_op_fn;
    logic [21:0]     w_ctrl;
    logic            w_done;
    logic            w_taken;
    logic            w_arith_ovf;
    state_t          w_boundary;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op_class <= '0;
            r_op_fn    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && op_valid) begin
                r_op_class <= op_class;
                r_op_fn    <= op_fn;
            end
        end
    end

    assign w_taken    = (r_op_class == C_BEQ) ? alu_zero : !alu_zero;
    assign w_boundary = run ? S_FETCH : S_IDLE;

`ifdef ALU_OVF_TRAP_EN
    assign w_arith_ovf = ovfl && (r_op_class == C_ADD || r_op_class == C_SUB ||
                                  r_op_class == C_ADDI);
`else
    // Wrapped results are written back; the flag is deliberately ignored.
    logic w_unused_ovfl;
    assign w_unused_ovfl = ovfl;
    assign w_arith_ovf   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_ctrl[B_PCW] = 1'b1;
                w_ctrl[B_IRW] = 1'b1;
                w_next        = S_DECODE;
            end
            S_DECODE: begin
                if (op_valid) w_next = (op_class <= C_BNE) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                w_ctrl[7:6]  = 2'b01;
                w_ctrl[B_ZW] = 1'b1;
                case (r_op_class)
                    C_ADD, C_SUB: begin
                        w_ctrl[5:4]      = 2'b01;
                        w_ctrl[B_ADDSUB] = (r_op_class == C_SUB);
                        w_next           = S_WB;
                    end
                    C_LOGIC, C_SHIFT: begin
                        w_ctrl[1:0] = (r_op_class == C_LOGIC) ? 2'b01 : 2'b10;
                        w_ctrl[3:2] = r_op_fn;
                        w_ctrl[5:4] = 2'b01;
                        w_next      = S_WB;
                    end
                    C_ADDI: begin
                        w_ctrl[5:4] = 2'b10;
                        w_next      = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        w_ctrl[5:4] = 2'b10;
                        w_next      = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        w_ctrl[5:4]      = 2'b01;
                        w_ctrl[B_ADDSUB] = 1'b1;
                        w_ctrl[B_ZW]     = 1'b0;
                        if (w_taken) begin
                            w_next = S_BRANCH;
                        end else begin
                            w_done = 1'b1;
                            w_next = w_boundary;
                        end
                    end
                    default: begin
                        w_ctrl = '0;
                        w_next = S_TRAP;
                    end
                endcase
                if (w_arith_ovf) w_next = S_TRAP;
            end
            S_MEM: begin
                if (r_op_class == C_LOAD) begin
                    w_ctrl[B_MEMRD] = 1'b1;
                    w_next          = S_WB;
                end else begin
                    w_ctrl[B_MEMWR] = 1'b1;
                    w_done          = 1'b1;
                    w_next          = w_boundary;
                end
            end
            S_WB: begin
                w_ctrl[B_REGW] = 1'b1;
                w_done         = 1'b1;
                w_next         = w_boundary;
            end
            S_BRANCH: begin
                w_ctrl[5:4]   = 2'b11;
                w_ctrl[B_PCW] = 1'b1;
                w_done        = 1'b1;
                w_next        = w_boundary;
            end
            S_TRAP: begin
                if (trap_clr) w_next = w_boundary;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign ctrl_out = w_ctrl;
    assign done     = w_done;
    assign op_ready = (r_state == S_DECODE);
    assign trap     = (r_state == S_TRAP);

endmodule
